pcs_transmisor: RTL and testbench

PCS_TRANSMISOR -- requirements
Module: pcs_transmisor

---
 rtl/pcs_transmisor.sv | 171 +++++++++++++++++
 tb/tb_pcs_transmisor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_transmisor.sv
// 1000BASE-X PCS transmit: registers GMII octets and emits 8b/10b code-groups with idle,
// start, end-of-packet and error ordered sets, tracking running disparity.
module pcs_transmisor (
  input  logic       clk,
  input  logic       mr_main_reset,
  input  logic       TX_EN,
  input  logic       TX_ER,
  input  logic [7:0] TXD,
  output logic [9:0] tx_code_group,
  output logic       tx_even,
  output logic       transmitting
);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StData  = 4'b0010,
    StEndR1 = 4'b0100,
    StEndR2 = 4'b1000
  } state_e;

  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;

  // 5b/6b RD- column; the RD+ form is the complement for unbalanced codes and D.7.
  function automatic logic [5:0] enc6_neg(input logic [4:0] y);
    logic [5:0] c;
    case (y)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] enc4_neg(input logic [2:0] x);
    logic [3:0] c;
    case (x)
      3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;  default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // Returns {rd_after, abcdei, fghj}. K codes handled here are all K.x.7 (forced A7 form).
  function automatic logic [10:0] enc8b10b(input logic [7:0] oct, input logic is_k,
                                           input logic rd);
    logic [5:0] c6;
    logic [3:0] c4;
    logic       neutral6, neutral4, rd6, a7;
    c6       = enc6_neg(oct[4:0]);
    neutral6 = ($countones(c6) == 3);
    if (rd && (!neutral6 || oct[4:0] == 5'd7)) c6 = ~c6;
    rd6 = rd ^ !neutral6;
    a7  = (oct[7:5] == 3'd7) &&
          (is_k || (!rd6 && (oct[4:0] == 5'd17 || oct[4:0] == 5'd18 || oct[4:0] == 5'd20)) ||
           (rd6 && (oct[4:0] == 5'd11 || oct[4:0] == 5'd13 || oct[4:0] == 5'd14)));
    c4       = a7 ? 4'b0111 : enc4_neg(oct[7:5]);
    neutral4 = ($countones(c4) == 2);
    if (rd6 && (!neutral4 || oct[7:5] == 3'd3)) c4 = ~c4;
    return {rd6 ^ !neutral4, c6, c4};
  endfunction

  state_e      state_q, state_d;
  logic        tx_en_q, tx_er_q;
  logic [7:0]  txd_q;
  logic        rd_q, rd_d;
  logic [9:0]  cg_q, cg_d;
  logic        tx_even_q;
  logic        trans_q, trans_d;
  logic        emit_even;
  logic [7:0]  oct;
  logic        is_k, use_k285;
  logic [10:0] enc;

  // Parity of the slot being produced this cycle.
  assign emit_even = ~tx_even_q;

  always_comb begin
    state_d  = StIdle;
    trans_d  = 1'b0;
    oct      = 8'h00;
    is_k     = 1'b0;
    use_k285 = 1'b0;
    case (state_q)
      StIdle: begin
        if (!emit_even) begin
          oct = rd_q ? D16_2 : D5_6;
        end else if (tx_en_q) begin
          oct     = K27_7;
          is_k    = 1'b1;
          state_d = StData;
          trans_d = 1'b1;
        end else begin
          use_k285 = 1'b1;
        end
      end
      StData: begin
        trans_d = 1'b1;
        state_d = StData;
        if (!tx_en_q) begin
          oct     = K29_7;
          is_k    = 1'b1;
          state_d = StEndR1;
        end else if (tx_er_q) begin
          oct  = K30_7;
          is_k = 1'b1;
        end else begin
          oct = txd_q;
        end
      end
      StEndR1: begin
        oct  = K23_7;
        is_k = 1'b1;
        // A second /R/ keeps the following idle run starting on an even slot.
        state_d = emit_even ? StEndR2 : StIdle;
      end
      StEndR2: begin
        oct  = K23_7;
        is_k = 1'b1;
      end
      default: use_k285 = 1'b1;
    endcase

    enc = enc8b10b(oct, is_k, rd_q);
    if (use_k285) begin
      cg_d = rd_q ? K28_5_POS : K28_5_NEG;
      rd_d = ~rd_q;
    end else begin
      cg_d = enc[9:0];
      rd_d = enc[10];
    end
  end

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      txd_q     <= 8'h00;
      state_q   <= StIdle;
      rd_q      <= 1'b1;
      cg_q      <= K28_5_NEG;
      tx_even_q <= 1'b1;
      trans_q   <= 1'b0;
    end else begin
      tx_en_q   <= TX_EN;
      tx_er_q   <= TX_ER;
      txd_q     <= TXD;
      state_q   <= state_d;
      rd_q      <= rd_d;
      cg_q      <= cg_d;
      tx_even_q <= ~tx_even_q;
      trans_q   <= trans_d;
    end
  end

  assign tx_code_group = cg_q;
  assign tx_even       = tx_even_q;
  assign transmitting  = trans_q;

endmodule

// File: tb/tb_pcs_transmisor.sv
// Bench for pcs_transmisor: directed framing cases plus random frames against a
// behavioural ordered-set / 8b/10b reference model and an independent disparity checker.
module tb_pcs_transmisor;

  logic       clk = 1'b0;
  logic       mr_main_reset = 1'b1;
  logic       TX_EN = 1'b0;
  logic       TX_ER = 1'b0;
  logic [7:0] TXD = 8'h00;
  logic [9:0] tx_code_group;
  logic       tx_even;
  logic       transmitting;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcs_transmisor dut (
    .clk          (clk),
    .mr_main_reset(mr_main_reset),
    .TX_EN        (TX_EN),
    .TX_ER        (TX_ER),
    .TXD          (TXD),
    .tx_code_group(tx_code_group),
    .tx_even      (tx_even),
    .transmitting (transmitting)
  );

  localparam logic [9:0] K28N = 10'b0011111010, K28P = 10'b1100000101;
  localparam logic [9:0] SN   = 10'b1101101000, SP   = 10'b0010010111;
  localparam logic [9:0] TN   = 10'b1011101000, TP   = 10'b0100010111;
  localparam logic [9:0] RN   = 10'b1110101000, RP   = 10'b0001010111;
  localparam logic [9:0] VN   = 10'b0111101000, VP   = 10'b1000010111;
  localparam logic [9:0] D0_0N = 10'b1001110100, D16_2P = 10'b1001000101;

  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                     4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                     4'b0010, 4'b1010, 4'b0110, 4'b0001};

  // Reference model state: emitted-slot parity, disparity, frame phase, registered inputs.
  logic       m_rd, m_even, m_tx, m_en, m_er;
  logic [7:0] m_d;
  int         m_mode;  // 0 idle, 1 in frame, 2 sending /R/
  logic       chk_rd;

  function automatic logic [9:0] denc(input logic [7:0] b, input logic rd);
    int         y, x, n6;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       r;
    y  = int'(b[4:0]);
    x  = int'(b[7:5]);
    s6 = rd ? T6P[y] : T6N[y];
    n6 = $countones(s6);
    r  = (n6 > 3) ? 1'b1 : ((n6 < 3) ? 1'b0 : rd);
    if (x == 7 && ((!r && (y == 17 || y == 18 || y == 20)) ||
                   (r && (y == 11 || y == 13 || y == 14))))
      s4 = r ? 4'b1000 : 4'b0111;
    else
      s4 = r ? T4P[x] : T4N[x];
    return {s6, s4};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 1'b1; m_even = 1'b1; m_tx = 1'b0; m_en = 1'b0; m_er = 1'b0; m_d = 8'h00;
    m_mode = 0; chk_rd = 1'b1;
  endtask

  task automatic step();
    logic [9:0] cw;
    int         ones;
    logic       legal;
    @(posedge clk);
    #1;
    cw     = '0;
    m_even = !m_even;
    m_tx   = 1'b0;
    case (m_mode)
      0: begin
        if (!m_even) cw = denc(m_rd ? 8'h50 : 8'hC5, m_rd);
        else if (m_en) begin cw = m_rd ? SP : SN; m_mode = 1; m_tx = 1'b1; end
        else cw = m_rd ? K28P : K28N;
      end
      1: begin
        m_tx = 1'b1;
        if (!m_en) begin cw = m_rd ? TP : TN; m_mode = 2; end
        else if (m_er) cw = m_rd ? VP : VN;
        else cw = denc(m_d, m_rd);
      end
      default: begin
        cw = m_rd ? RP : RN;
        if (!m_even) m_mode = 0;
      end
    endcase
    ones = $countones(cw);
    if (ones == 6) m_rd = 1'b1;
    else if (ones == 4) m_rd = 1'b0;
    m_en = TX_EN; m_er = TX_ER; m_d = TXD;
    chk("code_group", tx_code_group, cw);
    chk("tx_even", {9'd0, tx_even}, {9'd0, m_even});
    chk("transmitting", {9'd0, transmitting}, {9'd0, m_tx});
    // Disparity checker driven only by what the DUT actually emitted.
    ones  = $countones(tx_code_group);
    legal = (ones == 5) || (ones == 6 && !chk_rd) || (ones == 4 && chk_rd);
    chk("disparity", {9'd0, legal}, 10'd1);
    if (ones == 6) chk_rd = 1'b1;
    else if (ones == 4) chk_rd = 1'b0;
  endtask

  task automatic drive(input logic en, input logic er, input logic [7:0] d);
    TX_EN = en; TX_ER = er; TXD = d;
    step();
  endtask

  task automatic align(input logic want_even);
    if (m_even != want_even) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cg"}, tx_code_group, K28N);
    chk({tag, "_even"}, {9'd0, tx_even}, 10'd1);
    chk({tag, "_tx"}, {9'd0, transmitting}, 10'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tc;
    logic [9:0] idle_pat [2];
    model_reset();
    #2 mr_main_reset = 1'b0;
    TX_EN = 1'b1; TXD = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_hold");
    TX_EN = 1'b0; TXD = 8'h00;
    mr_main_reset = 1'b1;
    model_reset();

    // Idle after release: D16.2+, K28.5- alternating
    idle_pat[0] = D16_2P;
    idle_pat[1] = K28N;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 8'($urandom));
      chk("idle_pattern", tx_code_group, idle_pat[i % 2]);
    end

    // Two-octet frame, even aligned
    align(1'b1);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h00); chk("f2_S", tx_code_group, SN); tc = int'(transmitting);
    drive(1'b0, 1'b0, 8'h00); chk("f2_D0.0", tx_code_group, D0_0N); tc += int'(transmitting);
    drive(1'b0, 1'b0, 8'h00); chk("f2_T", tx_code_group, TN); tc += int'(transmitting);
    drive(1'b0, 1'b0, 8'h00); chk("f2_R", tx_code_group, RN); tc += int'(transmitting);
    drive(1'b0, 1'b0, 8'h00); chk("f2_K28.5", tx_code_group, K28N); tc += int'(transmitting);
    chk("f2_tx_slots", 10'(tc), 10'd3);

    // Three-octet frame: /T/ lands odd, so two /R/
    align(1'b1);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h00); chk("f3_S", tx_code_group, SN);
    drive(1'b1, 1'b0, 8'h00); chk("f3_D0", tx_code_group, D0_0N);
    drive(1'b0, 1'b0, 8'h00); chk("f3_D1", tx_code_group, D0_0N);
    drive(1'b0, 1'b0, 8'h00); chk("f3_T", tx_code_group, TN);
    chk("f3_T_odd", {9'd0, tx_even}, 10'd0);
    drive(1'b0, 1'b0, 8'h00); chk("f3_R1", tx_code_group, RN);
    drive(1'b0, 1'b0, 8'h00); chk("f3_R2", tx_code_group, RN);
    chk("f3_tx_after_T", {9'd0, transmitting}, 10'd0);
    drive(1'b0, 1'b0, 8'h00); chk("f3_K28.5", tx_code_group, K28N);
    chk("f3_K_even", {9'd0, tx_even}, 10'd1);

    // TX_EN rising toward an odd slot: first octet dropped
    align(1'b0);
    drive(1'b1, 1'b0, 8'hAA); chk("mis_K28.5", tx_code_group, K28N);
    drive(1'b1, 1'b0, 8'h11); chk("mis_idleD", tx_code_group, D16_2P);
    chk("mis_not_tx", {9'd0, transmitting}, 10'd0);
    drive(1'b1, 1'b0, 8'h00); chk("mis_S", tx_code_group, SN);
    drive(1'b0, 1'b0, 8'h00); chk("mis_D0.0", tx_code_group, D0_0N);
    drive(1'b0, 1'b0, 8'h00); chk("mis_T", tx_code_group, TN);
    repeat (3) drive(1'b0, 1'b0, 8'h00);

    // TX_ER on one mid-frame octet
    align(1'b1);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h00); chk("err_S", tx_code_group, SN);
    drive(1'b1, 1'b1, 8'h00); chk("err_D0", tx_code_group, D0_0N);
    drive(1'b1, 1'b0, 8'h00); chk("err_V", tx_code_group, VN);
    drive(1'b0, 1'b0, 8'h00); chk("err_D1", tx_code_group, D0_0N);
    drive(1'b0, 1'b0, 8'h00); chk("err_T", tx_code_group, TN);
    repeat (3) drive(1'b0, 1'b0, 8'h00);

    // Reset mid-frame takes effect without a clock edge
    align(1'b1);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h3C);
    drive(1'b1, 1'b0, 8'hC3);
    chk("pre_abort_tx", {9'd0, transmitting}, 10'd1);
    #3 mr_main_reset = 1'b0;
    #1 chk_reset_outputs("abort_async");
    @(posedge clk);
    #1 chk_reset_outputs("abort_held");
    TXD = 8'($urandom);
    mr_main_reset = 1'b1;
    model_reset();

    // Random frames, gaps and errors
    for (int f = 0; f < 40; f++) begin
      int gap, len;
      gap = $urandom_range(1, 4);
      len = $urandom_range(1, 12);
      for (int i = 0; i < gap; i++) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int i = 0; i < len; i++)
        drive(1'b1, ($urandom_range(0, 7) == 0), 8'($urandom));
    end
    repeat (6) drive(1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
